// File: rtl/usr_input_debounce.sv
// usr_input_debounce: synchronises and debounces raw key/switch lines, producing
// clean levels, single-cycle edge pulses and hold-to-repeat pulses for keys.
//
// Repeat FSM states (one FSM per key):
//   state    | meaning
//   ST_IDLE  | key released, repeat counter held at zero
//   ST_HOLD  | key pressed, timing the delay to the first repeat
//   ST_RPT   | key still held, issuing periodic repeats
module usr_input_debounce #(
  parameter int N_KEY         = 3,
  parameter int N_SW          = 3,
  parameter int DB_CYCLES     = 1_000_000,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic             fpga_clk_50,
  input  logic             fpga_rst_n,
  input  logic [N_KEY-1:0] usr_key_i,
  input  logic [N_SW-1:0]  usr_sw_i,
  output logic [N_KEY-1:0] key_level_o,
  output logic [N_KEY-1:0] key_press_o,
  output logic [N_KEY-1:0] key_release_o,
  output logic [N_KEY-1:0] key_repeat_o,
  output logic [N_SW-1:0]  sw_level_o,
  output logic [N_SW-1:0]  sw_change_o
);

  localparam int DB_W   = $clog2(DB_CYCLES);
  localparam int RP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RP_W   = $clog2(RP_MAX);

  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DB_CYCLES - 1);
  localparam logic [RP_W-1:0] HOLD_LAST   = RP_W'(HOLD_CYCLES - 1);
  localparam logic [RP_W-1:0] REPEAT_LAST = RP_W'(REPEAT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_RPT  = 2'd2;

  logic [N_KEY-1:0] key_s1, key_s2;
  logic [N_SW-1:0]  sw_s1, sw_s2;

  // Synchronisers idle at "released" for keys so reset never looks like a press.
  always_ff @(posedge fpga_clk_50) begin
    if (!fpga_rst_n) begin
      key_s1 <= '1;
      key_s2 <= '1;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      key_s1 <= usr_key_i;
      key_s2 <= key_s1;
      sw_s1  <= usr_sw_i;
      sw_s2  <= sw_s1;
    end
  end

  for (genvar i = 0; i < N_KEY; i++) begin : g_key
    logic            cmp, done, rise, fall;
    logic            lvl, press_q, rel_q, rpt_q;
    logic [DB_W-1:0] db_cnt;
    logic [1:0]      state;
    logic [RP_W-1:0] rp_cnt;

    assign cmp  = ~key_s2[i];
    assign done = (cmp != lvl) && (db_cnt == DB_LAST);
    assign rise = done & cmp;
    assign fall = done & ~cmp;

    always_ff @(posedge fpga_clk_50) begin
      if (!fpga_rst_n) begin
        lvl     <= 1'b0;
        db_cnt  <= '0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        press_q <= rise;
        rel_q   <= fall;
        if (cmp == lvl) begin
          db_cnt <= '0;
        end else if (done) begin
          lvl    <= cmp;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end
    end

    // A release on the same edge as a due repeat wins and suppresses it.
    always_ff @(posedge fpga_clk_50) begin
      if (!fpga_rst_n) begin
        state  <= ST_IDLE;
        rp_cnt <= '0;
        rpt_q  <= 1'b0;
      end else begin
        rpt_q <= 1'b0;
        case (state)
          ST_IDLE: begin
            rp_cnt <= '0;
            if (rise) state <= ST_HOLD;
          end
          ST_HOLD: begin
            if (fall) begin
              state  <= ST_IDLE;
              rp_cnt <= '0;
            end else if (rp_cnt == HOLD_LAST) begin
              rpt_q  <= 1'b1;
              rp_cnt <= '0;
              state  <= ST_RPT;
            end else begin
              rp_cnt <= rp_cnt + RP_W'(1);
            end
          end
          ST_RPT: begin
            if (fall) begin
              state  <= ST_IDLE;
              rp_cnt <= '0;
            end else if (rp_cnt == REPEAT_LAST) begin
              rpt_q  <= 1'b1;
              rp_cnt <= '0;
            end else begin
              rp_cnt <= rp_cnt + RP_W'(1);
            end
          end
          default: begin
            state  <= ST_IDLE;
            rp_cnt <= '0;
          end
        endcase
      end
    end

    assign key_level_o[i]   = lvl;
    assign key_press_o[i]   = press_q;
    assign key_release_o[i] = rel_q;
    assign key_repeat_o[i]  = rpt_q;
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    logic            cmp, done;
    logic            lvl, chg_q;
    logic [DB_W-1:0] db_cnt;

    assign cmp  = sw_s2[i];
    assign done = (cmp != lvl) && (db_cnt == DB_LAST);

    always_ff @(posedge fpga_clk_50) begin
      if (!fpga_rst_n) begin
        lvl    <= 1'b0;
        db_cnt <= '0;
        chg_q  <= 1'b0;
      end else begin
        chg_q <= done;
        if (cmp == lvl) begin
          db_cnt <= '0;
        end else if (done) begin
          lvl    <= cmp;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end
    end

    assign sw_level_o[i]  = lvl;
    assign sw_change_o[i] = chg_q;
  end

endmodule

// File: tb/tb_usr_input_debounce.sv
// Bench for usr_input_debounce: directed timing sequences, a level table and a
// randomized run checked every cycle against a sample-history reference model.
module tb_usr_input_debounce;
  localparam int DB   = 4;
  localparam int HOLD = 20;
  localparam int RPT  = 8;

  logic       fpga_clk_50 = 1'b0;
  logic       fpga_rst_n;
  logic [2:0] usr_key_i, usr_sw_i;
  logic [2:0] key_level_o, key_press_o, key_release_o, key_repeat_o;
  logic [2:0] sw_level_o, sw_change_o;

  usr_input_debounce #(
    .N_KEY(3), .N_SW(3), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(RPT)
  ) dut (
    .fpga_clk_50   (fpga_clk_50),
    .fpga_rst_n    (fpga_rst_n),
    .usr_key_i     (usr_key_i),
    .usr_sw_i      (usr_sw_i),
    .key_level_o   (key_level_o),
    .key_press_o   (key_press_o),
    .key_release_o (key_release_o),
    .key_repeat_o  (key_repeat_o),
    .sw_level_o    (sw_level_o),
    .sw_change_o   (sw_change_o)
  );

  initial forever #10 fpga_clk_50 = ~fpga_clk_50;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic run_until(input int t);
    while (cyc < t) @(negedge fpga_clk_50);
  endtask

  // Reference model: a channel's level flips when the DB most recent
  // synchronised samples all disagree with it; repeats follow from press time.
  logic [5:0] hist [0:DB];
  logic [5:0] m_lvl   = '0;
  logic [2:0] m_press = '0, m_rel = '0, m_rpt = '0, m_swchg = '0;
  int         press_cyc [3];

  always @(posedge fpga_clk_50) begin : model
    logic [5:0] nv, chg, nl;
    bit         all_diff;
    int         d;
    cyc++;
    if (!fpga_rst_n) begin
      m_lvl = '0; m_press = '0; m_rel = '0; m_rpt = '0; m_swchg = '0;
      for (int j = 0; j <= DB; j++) hist[j] = '0;
    end else begin
      nv  = {usr_sw_i, ~usr_key_i};
      chg = '0;
      for (int c = 0; c < 6; c++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= DB; j++)
          if (hist[j][c] == m_lvl[c]) all_diff = 1'b0;
        chg[c] = all_diff;
      end
      nl      = m_lvl ^ chg;
      m_press = chg[2:0] & nl[2:0];
      m_rel   = chg[2:0] & ~nl[2:0];
      m_swchg = chg[5:3];
      for (int k = 0; k < 3; k++) begin
        if (m_press[k]) press_cyc[k] = cyc;
        d = cyc - press_cyc[k];
        m_rpt[k] = nl[k] && !m_press[k] && (d >= HOLD) && (((d - HOLD) % RPT) == 0);
      end
      m_lvl = nl;
      for (int j = DB; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = nv;
    end
  end

  always @(negedge fpga_clk_50) begin
    if (chk_en) begin
      chk("model_key_level", 8'(key_level_o),   8'(m_lvl[2:0]));
      chk("model_key_press", 8'(key_press_o),   8'(m_press));
      chk("model_key_rel",   8'(key_release_o), 8'(m_rel));
      chk("model_key_rpt",   8'(key_repeat_o),  8'(m_rpt));
      chk("model_sw_level",  8'(sw_level_o),    8'(m_lvl[5:3]));
      chk("model_sw_change", 8'(sw_change_o),   8'(m_swchg));
    end
  end

  typedef struct {
    logic [2:0] key;
    logic [2:0] sw;
    logic [2:0] exp_key_lvl;
    logic [2:0] exp_sw_lvl;
  } vec_t;

  vec_t        tbl [7];
  logic [11:0] acc;
  int          e, f, g, p, r;

  initial begin
    tbl[0] = '{3'b111, 3'b000, 3'b000, 3'b000};
    tbl[1] = '{3'b110, 3'b001, 3'b001, 3'b001};
    tbl[2] = '{3'b100, 3'b011, 3'b011, 3'b011};
    tbl[3] = '{3'b000, 3'b111, 3'b111, 3'b111};
    tbl[4] = '{3'b011, 3'b100, 3'b100, 3'b100};
    tbl[5] = '{3'b101, 3'b010, 3'b010, 3'b010};
    tbl[6] = '{3'b111, 3'b000, 3'b000, 3'b000};

    fpga_rst_n = 1'b0;
    usr_key_i  = 3'b111;
    usr_sw_i   = 3'b000;
    @(negedge fpga_clk_50);
    chk_en = 1'b1;
    @(negedge fpga_clk_50);
    @(negedge fpga_clk_50);
    chk("rst_key_level", 8'(key_level_o),   8'd0);
    chk("rst_key_press", 8'(key_press_o),   8'd0);
    chk("rst_key_rel",   8'(key_release_o), 8'd0);
    chk("rst_key_rpt",   8'(key_repeat_o),  8'd0);
    chk("rst_sw_level",  8'(sw_level_o),    8'd0);
    chk("rst_sw_change", 8'(sw_change_o),   8'd0);
    fpga_rst_n = 1'b1;
    acc = '0;
    repeat (20) begin
      @(negedge fpga_clk_50);
      acc = acc | {key_press_o, key_release_o, key_repeat_o, sw_change_o};
    end
    chk("rst_quiet", 8'(acc), 8'd0);

    // clean press/release on key0
    usr_key_i[0] = 1'b0; e = cyc + 1;
    run_until(e + 4); chk("press0_early", 8'(key_press_o[0]), 8'd0);
    chk("level0_early", 8'(key_level_o[0]), 8'd0);
    run_until(e + 5); chk("press0_at", 8'(key_press_o[0]), 8'd1);
    chk("level0_at", 8'(key_level_o[0]), 8'd1);
    run_until(e + 6); chk("press0_width", 8'(key_press_o[0]), 8'd0);
    usr_key_i[0] = 1'b1; f = cyc + 1;
    run_until(f + 4); chk("rel0_early", 8'(key_release_o[0]), 8'd0);
    run_until(f + 5); chk("rel0_at", 8'(key_release_o[0]), 8'd1);
    chk("level0_off", 8'(key_level_o[0]), 8'd0);
    run_until(f + 6); chk("rel0_width", 8'(key_release_o[0]), 8'd0);

    // bouncing key1
    acc = '0;
    for (int rr = 0; rr < 5; rr++) begin
      for (int j = 0; j < 4; j++) begin
        usr_key_i[1] = (j == 3);
        @(negedge fpga_clk_50);
        acc = acc | 12'({key_level_o[1], key_press_o[1], key_release_o[1], key_repeat_o[1]});
      end
    end
    usr_key_i[1] = 1'b0; g = cyc + 1;
    while (cyc < g + 4) begin
      @(negedge fpga_clk_50);
      if (cyc < g + 4) acc = acc | 12'({key_level_o[1], key_press_o[1]});
    end
    chk("bounce_quiet", 8'(acc), 8'd0);
    chk("press1_early", 8'(key_press_o[1]), 8'd0);
    run_until(g + 5); chk("press1_at", 8'(key_press_o[1]), 8'd1);
    usr_key_i[1] = 1'b1;
    run_until(cyc + 8);

    // hold-repeat on key2, release landing on a due repeat
    usr_key_i[2] = 1'b0; e = cyc + 1; p = e + 5;
    run_until(p);      chk("press2_at", 8'(key_press_o[2]), 8'd1);
    run_until(p + 19); chk("rpt2_early", 8'(key_repeat_o[2]), 8'd0);
    run_until(p + 20); chk("rpt2_first", 8'(key_repeat_o[2]), 8'd1);
    run_until(p + 21); chk("rpt2_width", 8'(key_repeat_o[2]), 8'd0);
    run_until(p + 27); chk("rpt2_gap", 8'(key_repeat_o[2]), 8'd0);
    run_until(p + 28); chk("rpt2_second", 8'(key_repeat_o[2]), 8'd1);
    run_until(p + 36); chk("rpt2_third", 8'(key_repeat_o[2]), 8'd1);
    chk("rpt2_no_press", 8'(key_press_o[2]), 8'd0);
    run_until(p + 38); usr_key_i[2] = 1'b1;
    run_until(p + 43); chk("level2_held", 8'(key_level_o[2]), 8'd1);
    run_until(p + 44); chk("rel2_at", 8'(key_release_o[2]), 8'd1);
    chk("rpt2_suppressed", 8'(key_repeat_o[2]), 8'd0);
    acc = '0;
    repeat (20) begin
      @(negedge fpga_clk_50);
      acc = acc | 12'(key_repeat_o);
    end
    chk("rpt2_after_rel", 8'(acc), 8'd0);

    // switches: glitch, clean change, simultaneous change
    usr_sw_i[1] = 1'b1;
    @(negedge fpga_clk_50); @(negedge fpga_clk_50);
    usr_sw_i[1] = 1'b0;
    acc = '0;
    repeat (10) begin
      @(negedge fpga_clk_50);
      acc = acc | 12'({sw_level_o, sw_change_o});
    end
    chk("sw_glitch", 8'(acc), 8'd0);
    usr_sw_i[1] = 1'b1; e = cyc + 1;
    run_until(e + 4); chk("sw1_early", 8'(sw_change_o), 8'd0);
    run_until(e + 5); chk("sw1_change", 8'(sw_change_o), 8'b010);
    chk("sw1_level", 8'(sw_level_o), 8'b010);
    run_until(e + 6); chk("sw1_width", 8'(sw_change_o), 8'd0);
    usr_sw_i[0] = 1'b1; usr_sw_i[2] = 1'b1; e = cyc + 1;
    run_until(e + 5); chk("sw02_change", 8'(sw_change_o), 8'b101);
    chk("sw02_level", 8'(sw_level_o), 8'b111);
    usr_sw_i = 3'b000;
    run_until(cyc + 8);

    // reset while key0 is auto-repeating
    usr_key_i[0] = 1'b0; e = cyc + 1; p = e + 5;
    run_until(p + 24);
    fpga_rst_n = 1'b0;
    run_until(cyc + 1);
    chk("midrst_level", 8'(key_level_o), 8'd0);
    chk("midrst_pulses", 8'(key_press_o | key_release_o | key_repeat_o), 8'd0);
    run_until(cyc + 1);
    fpga_rst_n = 1'b1; r = cyc + 1;
    run_until(r + 4);  chk("repress0_early", 8'(key_press_o[0]), 8'd0);
    run_until(r + 5);  chk("repress0_at", 8'(key_press_o[0]), 8'd1);
    run_until(r + 24); chk("rerpt0_early", 8'(key_repeat_o[0]), 8'd0);
    run_until(r + 25); chk("rerpt0_at", 8'(key_repeat_o[0]), 8'd1);
    usr_key_i[0] = 1'b1;
    run_until(cyc + 8);

    for (int i = 0; i < 7; i++) begin
      usr_key_i = tbl[i].key;
      usr_sw_i  = tbl[i].sw;
      run_until(cyc + 8);
      chk($sformatf("tbl%0d_key_level", i), 8'(key_level_o), 8'(tbl[i].exp_key_lvl));
      chk($sformatf("tbl%0d_sw_level", i),  8'(sw_level_o),  8'(tbl[i].exp_sw_lvl));
    end

    for (int seg = 0; seg < 12; seg++) begin
      int den;
      logic [2:0] km, sm;
      den = (seg % 3 == 0) ? 3 : ((seg % 3 == 1) ? 8 : 40);
      for (int n = 0; n < 200; n++) begin
        @(negedge fpga_clk_50);
        km = {($urandom_range(den - 1) == 0), ($urandom_range(den - 1) == 0),
              ($urandom_range(den - 1) == 0)};
        sm = {($urandom_range(den - 1) == 0), ($urandom_range(den - 1) == 0),
              ($urandom_range(den - 1) == 0)};
        usr_key_i  = usr_key_i ^ km;
        usr_sw_i   = usr_sw_i ^ sm;
        fpga_rst_n = ($urandom_range(299) != 0);
      end
    end

    fpga_rst_n = 1'b1;
    usr_key_i  = 3'b111;
    usr_sw_i   = 3'b000;
    run_until(cyc + 10);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
